// File: rtl/fetch_unit.sv
// Instruction fetch sequencer for the 16-bit SAP computer: issues one read per
// fetch request, loads the instruction register and pulses the PC increment.
module fetch_unit #(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc_in,
  input  logic        fetch_start,
  input  logic        flush,
  input  logic        mem_rd_ack,
  input  logic [15:0] mem_rd_data,
  output logic [15:0] mem_addr,
  output logic        mem_rd_req,
  output logic [15:0] ir_out,
  output logic        ir_valid,
  output logic        pc_inc,
  output logic        busy,
  output logic        fetch_err
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  localparam bit             TO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT_CYC == 0) ? {CNT_W{1'b0}}
                                                            : CNT_W'(TIMEOUT_CYC - 1);

  state_t           state_q, state_d;
  logic [15:0]      mem_addr_q, mem_addr_d;
  logic             mem_rd_req_q, mem_rd_req_d;
  logic [15:0]      ir_q, ir_d;
  logic             ir_valid_q, ir_valid_d;
  logic             pc_inc_q, pc_inc_d;
  logic             fetch_err_q, fetch_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A fetch is not accepted while pc_inc is high so the PC has settled on the next address.
  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    mem_rd_req_d = mem_rd_req_q;
    ir_d         = ir_q;
    ir_valid_d   = 1'b0;
    pc_inc_d     = 1'b0;
    fetch_err_d  = 1'b0;
    cnt_d        = cnt_q;

    case (state_q)
      IDLE: begin
        if (fetch_start && !pc_inc_q && !flush) begin
          state_d      = REQ;
          mem_addr_d   = pc_in;
          mem_rd_req_d = 1'b1;
          cnt_d        = '0;
        end
      end
      REQ: begin
        if (flush) begin
          mem_rd_req_d = 1'b0;
          state_d      = IDLE;
        end else if (mem_rd_ack) begin
          ir_d         = mem_rd_data;
          ir_valid_d   = 1'b1;
          pc_inc_d     = 1'b1;
          mem_rd_req_d = 1'b0;
          state_d      = IDLE;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          mem_rd_req_d = 1'b0;
          fetch_err_d  = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d      = IDLE;
        mem_rd_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mem_addr_q   <= '0;
      mem_rd_req_q <= 1'b0;
      ir_q         <= '0;
      ir_valid_q   <= 1'b0;
      pc_inc_q     <= 1'b0;
      fetch_err_q  <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_rd_req_q <= mem_rd_req_d;
      ir_q         <= ir_d;
      ir_valid_q   <= ir_valid_d;
      pc_inc_q     <= pc_inc_d;
      fetch_err_q  <= fetch_err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_rd_req = mem_rd_req_q;
  assign ir_out     = ir_q;
  assign ir_valid   = ir_valid_q;
  assign pc_inc     = pc_inc_q;
  assign fetch_err  = fetch_err_q;
  assign busy       = (state_q == REQ);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a transaction driver plays PC and memory and queues the
// expected outcome of each fetch; a monitor checks the DUT against that queue.
module tb_fetch_unit;

  localparam int TB_TO   = 16;
  localparam int K_ACK   = 0;
  localparam int K_FLUSH = 1;
  localparam int K_TO    = 2;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc_in;
  logic        fetch_start;
  logic        flush;
  logic        mem_rd_ack;
  logic [15:0] mem_rd_data;
  logic [15:0] mem_addr;
  logic        mem_rd_req;
  logic [15:0] ir_out;
  logic        ir_valid;
  logic        pc_inc;
  logic        busy;
  logic        fetch_err;

  typedef struct {
    logic [15:0] addr;
    int          kind;
    int          reqCycles;
    logic [15:0] ir;
  } exp_t;

  exp_t        expQ[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          prevKind   = -1;
  logic [15:0] modelIr    = 16'h0000;
  bit          monEnable  = 0;
  bit          prevBusy   = 0;
  int          reqCnt     = 0;

  fetch_unit #(.TIMEOUT_CYC(TB_TO), .CNT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_in      (pc_in),
    .fetch_start(fetch_start),
    .flush      (flush),
    .mem_rd_ack (mem_rd_ack),
    .mem_rd_data(mem_rd_data),
    .mem_addr   (mem_addr),
    .mem_rd_req (mem_rd_req),
    .ir_out     (ir_out),
    .ir_valid   (ir_valid),
    .pc_inc     (pc_inc),
    .busy       (busy),
    .fetch_err  (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".mem_addr"},   32'(mem_addr),   32'h0);
    checkOutput({tag, ".mem_rd_req"}, 32'(mem_rd_req), 32'h0);
    checkOutput({tag, ".ir_out"},     32'(ir_out),     32'h0);
    checkOutput({tag, ".ir_valid"},   32'(ir_valid),   32'h0);
    checkOutput({tag, ".pc_inc"},     32'(pc_inc),     32'h0);
    checkOutput({tag, ".busy"},       32'(busy),       32'h0);
    checkOutput({tag, ".fetch_err"},  32'(fetch_err),  32'h0);
  endtask

  task automatic idleCycles(input int n, input bit ackOn);
    for (int i = 0; i < n; i++) begin
      fetch_start = 1'b0;
      flush       = 1'b0;
      mem_rd_ack  = ackOn;
      mem_rd_data = 16'($urandom);
      @(negedge clk);
    end
    mem_rd_ack = 1'b0;
    prevKind   = -1;
  endtask

  // One fetch transaction; the outcome is the earliest of flush, ack and timeout,
  // ties resolved flush first, then ack.
  task automatic applyStimulus(input logic [15:0] addr, input logic [15:0] data,
                               input bit hasAck, input int w,
                               input bit hasFlush, input int f,
                               input bit blockFlush, input bit b2b);
    int   e;
    int   kind;
    int   ackAt;
    int   flushAt;
    exp_t ex;
    if (!b2b) begin
      repeat ($urandom_range(1, 3)) begin
        fetch_start = 1'b0;
        flush       = 1'($urandom);
        mem_rd_ack  = 1'($urandom);
        mem_rd_data = 16'($urandom);
        pc_in       = 16'($urandom);
        @(negedge clk);
      end
    end else if (prevKind == K_ACK) begin
      pc_in       = addr - 16'd1;
      fetch_start = 1'b1;
      flush       = 1'b0;
      mem_rd_ack  = 1'b0;
      @(negedge clk);
    end
    if (blockFlush) begin
      pc_in       = ~addr;
      fetch_start = 1'b1;
      flush       = 1'b1;
      mem_rd_ack  = 1'b0;
      @(negedge clk);
    end
    pc_in       = addr;
    fetch_start = 1'b1;
    flush       = 1'b0;
    mem_rd_ack  = 1'($urandom);
    mem_rd_data = 16'($urandom);

    ackAt   = hasAck   ? w : 1000;
    flushAt = hasFlush ? f : 1000;
    e = TB_TO - 1;
    if (ackAt < e)   e = ackAt;
    if (flushAt < e) e = flushAt;
    if (flushAt == e)    kind = K_FLUSH;
    else if (ackAt == e) kind = K_ACK;
    else                 kind = K_TO;
    if (kind == K_ACK) modelIr = data;
    ex.addr      = addr;
    ex.kind      = kind;
    ex.reqCycles = e + 1;
    ex.ir        = modelIr;
    expQ.push_back(ex);
    @(negedge clk);

    for (int n = 0; n <= e; n++) begin
      fetch_start = 1'($urandom);
      pc_in       = 16'($urandom);
      mem_rd_ack  = hasAck && (n == w);
      mem_rd_data = (hasAck && (n == w)) ? data : 16'($urandom);
      flush       = hasFlush && (n == f);
      @(negedge clk);
    end
    fetch_start = 1'b0;
    flush       = 1'b0;
    mem_rd_ack  = 1'b0;
    prevKind    = kind;
  endtask

  // Monitor: tracks each REQ window and checks the pulses in the cycle it closes.
  always @(negedge clk) begin
    if (monEnable) begin
      if (busy && !prevBusy) begin
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpectedFetch: fetch started at addr 0x%0h, none expected", mem_addr);
        end else begin
          checkOutput("startAddr", 32'(mem_addr), 32'(expQ[0].addr));
        end
        reqCnt = 1;
      end else if (busy) begin
        reqCnt++;
        if (expQ.size() != 0) checkOutput("holdAddr", 32'(mem_addr), 32'(expQ[0].addr));
      end
      checkOutput("reqMatchesBusy", 32'(mem_rd_req), 32'(busy));
      if (!busy && prevBusy) begin
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpectedEnd: fetch ended, none expected");
        end else begin
          exp_t ex;
          ex = expQ.pop_front();
          checkOutput("reqCycles", 32'(reqCnt),    32'(ex.reqCycles));
          checkOutput("irValid",   32'(ir_valid),  32'(ex.kind == K_ACK));
          checkOutput("pcInc",     32'(pc_inc),    32'(ex.kind == K_ACK));
          checkOutput("fetchErr",  32'(fetch_err), 32'(ex.kind == K_TO));
          checkOutput("irOut",     32'(ir_out),    32'(ex.ir));
        end
      end else begin
        checkOutput("noPulse", 32'({ir_valid, pc_inc, fetch_err}), 32'h0);
      end
    end
    prevBusy = busy;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    pc_in       = 16'h0000;
    fetch_start = 1'b0;
    flush       = 1'b0;
    mem_rd_ack  = 1'b0;
    mem_rd_data = 16'h0000;
    #12;
    checkResetValues("reset");
    @(negedge clk);
    rst_n     = 1'b1;
    monEnable = 1;

    applyStimulus(16'h000A, 16'h1234, 1, 0,  0, 0, 0, 0);
    applyStimulus(16'h000B, 16'h4321, 1, 0,  0, 0, 0, 1);
    applyStimulus(16'h0100, 16'h5A5A, 1, 4,  0, 0, 0, 0);
    applyStimulus(16'h0200, 16'hBEEF, 1, 2,  1, 2, 0, 0);
    applyStimulus(16'h0300, 16'h7777, 0, 0,  0, 0, 0, 0);
    idleCycles(3, 1);
    applyStimulus(16'h0400, 16'hA5A5, 1, 15, 0, 0, 0, 0);
    applyStimulus(16'h0401, 16'hC3C3, 1, 16, 0, 0, 0, 0);
    applyStimulus(16'h0500, 16'h0F0F, 1, 1,  0, 0, 1, 0);
    applyStimulus(16'h0600, 16'h1111, 0, 0,  1, 0, 0, 1);
    applyStimulus(16'h0601, 16'h2222, 1, 3,  0, 0, 1, 1);

    idleCycles(1, 0);
    monEnable   = 0;
    pc_in       = 16'h0055;
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    checkOutput("preReset.req",  32'(mem_rd_req), 32'h1);
    checkOutput("preReset.addr", 32'(mem_addr),   32'h55);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("asyncReset");
    @(negedge clk);
    rst_n   = 1'b1;
    modelIr = 16'h0000;
    @(negedge clk);
    prevKind  = -1;
    monEnable = 1;

    applyStimulus(16'h0020, 16'h600D, 1, 1, 0, 0, 0, 0);
    applyStimulus(16'h0010, 16'h1000, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i < 4; i++)
      applyStimulus(16'h0010 + 16'(i), 16'h1000 + 16'(i), 1, 0, 0, 0, 0, 1);

    for (int t = 0; t < 60; t++) begin
      int mode;
      int w;
      int f;
      mode = $urandom_range(0, 7);
      w    = $urandom_range(0, 5);
      f    = $urandom_range(0, 4);
      case (mode)
        5:       applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), w, 1, f,
                               ($urandom_range(0, 3) == 0), 1'($urandom));
        6:       applyStimulus(16'($urandom), 16'($urandom), 0, 0, 0, 0,
                               ($urandom_range(0, 3) == 0), 1'($urandom));
        7:       applyStimulus(16'($urandom), 16'($urandom), 1, $urandom_range(10, 17), 0, 0,
                               ($urandom_range(0, 3) == 0), 1'($urandom));
        default: applyStimulus(16'($urandom), 16'($urandom), 1, w, 0, 0,
                               ($urandom_range(0, 3) == 0), 1'($urandom));
      endcase
    end

    idleCycles(3, 1);
    checkOutput("queueEmpty", 32'(expQ.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer for the 16-bit SAP computer. It reads the instruction word at the address held by the program counter through a variable-latency request/acknowledge read port. It latches the word into the instruction register and returns a one-cycle increment pulse to the program counter. It sits between the program counter, which supplies the address and consumes `pc_inc`, and program memory. The control sequencer starts fetches and can flush an in-flight fetch on a jump.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 16: maximum cycles in REQ without an acknowledge before the fetch is aborted; 0 disables the timeout.
- `CNT_W`, default 5: width of the timeout counter; must hold `TIMEOUT_CYC`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `pc_in` in 16: current program counter value.
- `fetch_start` in 1: request one fetch (level, sampled each edge).
- `flush` in 1: abort any in-flight fetch (jump taken).
- `mem_rd_ack` in 1: memory read acknowledge; data valid when high.
- `mem_rd_data` in 16: memory read data.
- `mem_addr` out 16: registered read address.
- `mem_rd_req` out 1: registered read request.
- `ir_out` out 16: instruction register.
- `ir_valid` out 1: one-cycle pulse, `ir_out` newly loaded.
- `pc_inc` out 1: one-cycle pulse to the program counter.
- `busy` out 1: high while in REQ.
- `fetch_err` out 1: one-cycle pulse on timeout abort.

## Operation
- States: IDLE and REQ. `busy` = (state == REQ).
- IDLE → REQ at an edge where `fetch_start`=1, `pc_inc`=0 and `flush`=0. That edge captures `mem_addr` <= `pc_in`, sets `mem_rd_req` <= 1 and clears the timeout counter.
- `fetch_start` is ignored while in REQ and during the IDLE cycle in which `pc_inc` is high. This lets the program counter update before the next address is captured.
- In REQ, `mem_addr` and `mem_rd_req` are held stable until the fetch ends.
- Ack edge (REQ, `mem_rd_ack`=1, `flush`=0):
  - `ir_out` <= `mem_rd_data`.
  - `ir_valid` <= 1 and `pc_inc` <= 1, each for exactly one cycle.
  - `mem_rd_req` <= 0; state → IDLE.
- Flush edge (REQ, `flush`=1):
  - `mem_rd_req` <= 0; state → IDLE.
  - `ir_out` unchanged; no `ir_valid`, no `pc_inc`.
  - Flush wins over a simultaneous ack; the data is discarded.
- `flush` in IDLE has no effect except blocking a same-edge `fetch_start`.
- Timeout counter:
  - Increments each REQ cycle without an ack.
  - When `TIMEOUT_CYC`≠0 and the counter reaches `TIMEOUT_CYC`-1 with no ack: `mem_rd_req` <= 0, `fetch_err` pulses one cycle, state → IDLE, `ir_out` unchanged, no `pc_inc`.
  - An ack on that same edge wins over the timeout.
- Priority in REQ: flush > ack > timeout.
- `mem_rd_ack` seen while in IDLE is ignored.

## Timing
- Reset values (asynchronous on `rst_n`=0): state IDLE; `mem_addr`=0, `mem_rd_req`=0, `ir_out`=0, `ir_valid`=0, `pc_inc`=0, `busy`=0, `fetch_err`=0, counter=0.
- Reset mid-fetch drops `mem_rd_req` immediately, without waiting for a clock edge.
- Zero-wait memory (ack high in the first REQ cycle):
  - `fetch_start` sampled at edge 0.
  - `mem_rd_req` high in cycle 1.
  - Ack sampled at edge 1.
  - `ir_valid`/`pc_inc` high in cycle 2.
  - Earliest next `fetch_start` acceptance is edge 3, so there are 3 cycles per instruction.
- Memory with W wait cycles: `ir_valid` occurs W cycles later than the zero-wait case.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then `pc_in`=0x000A, `fetch_start` held, ack in the first REQ cycle with data 0x1234 → `mem_addr`=0x000A, `ir_out`=0x1234; `ir_valid` and `pc_inc` each high one cycle in cycle 2; next capture edge 3 with `pc_in`=0x000B.
- Ack delayed 4 cycles → `mem_rd_req` and `mem_addr` stable for 5 cycles; a `fetch_start` pulse during REQ is ignored; exactly one `pc_inc` results.
- `flush` and ack on the same edge (data 0xBEEF) → `ir_out` keeps its old value; no `ir_valid`, no `pc_inc`; IDLE next cycle.
- With `TIMEOUT_CYC`=16 and no ack → `mem_rd_req` high exactly 16 cycles, then `fetch_err` pulses once; a late ack in IDLE is ignored; `ir_out` unchanged.
- `rst_n` asserted during REQ → all outputs go to reset values asynchronously; after release, a new fetch at `pc_in`=0x0020 completes normally.
- `fetch_start` held continuously through 4 zero-wait fetches starting at `pc_in`=0x0010 → `mem_addr` sequence 0x0010..0x0013, exactly 4 `pc_inc` pulses, no address captured during a `pc_inc` cycle.
